df_deadlock_detector: RTL and testbench
=======================================

Name: df_deadlock_detector

Overview:
- Synthesizable dataflow deadlock detector that watches the stall signals of every dataflow process and channel in a region.
- Asserts a sticky find_df_deadlock when all active processes stay blocked with no channel traffic for THRESH consecutive cycles.
- Sits directly upstream of the dataflow monitor. Its find_df_deadlock output feeds each monitor's finish term. It also latches which processes and channels were involved, for the deadlock report.

Parameters:
- NUM_PROC, 3, number of dataflow processes watched
- NUM_CHAN, 3, number of FIFO/PIPO channels watched
- THRESH, 1000, consecutive fully-blocked cycles required to declare deadlock (must be >= 2)
- CNT_W, 16, width of the blocked-cycle counter (2**CNT_W > THRESH)

Ports:
- ap_clk, input, 1, clock
- ap_rst_n, input, 1, asynchronous active-low reset
- proc_start, input, NUM_PROC, per-process ap_start
- proc_done, input, NUM_PROC, per-process ap_done
- proc_in_stall, input, NUM_PROC, process blocked reading an input channel
- proc_out_stall, input, NUM_PROC, process blocked writing an output channel
- chan_rd_en, input, NUM_CHAN, channel read strobe
- chan_wr_en, input, NUM_CHAN, channel write strobe
- chan_rd_block, input, NUM_CHAN, consumer blocked on the channel
- chan_wr_block, input, NUM_CHAN, producer blocked on the channel
- clear, input, 1, synchronous return to IDLE
- find_df_deadlock, output, 1, sticky deadlock flag
- dl_proc_mask, output, NUM_PROC, processes blocked at detection
- dl_chan_mask, output, NUM_CHAN, channels blocked (rd_block | wr_block) at detection
- blocked_cnt, output, CNT_W, current consecutive blocked-cycle count
- state, output, 2, FSM state: 0 = IDLE, 1 = MONITOR, 2 = DEADLOCK

Behaviour:
- Reset (ap_rst_n low, asynchronous): all outputs and registers are 0 and the FSM is IDLE.
- Active tracking: proc_active[i] is a register.
  - Set on a cycle with proc_start[i] = 1 and proc_done[i] = 0.
  - Cleared on proc_done[i].
  - If start and done are both high in one cycle, done wins (active = 0).
- Derived signals:
  - blocked = proc_in_stall | proc_out_stall.
  - all_blocked = (|proc_active) and ((proc_active & ~blocked) == 0).
  - progress = |chan_rd_en or |chan_wr_en.
- IDLE:
  - blocked_cnt is 0.
  - Go to MONITOR on the cycle after any proc_active bit is set.
- MONITOR:
  - If all_blocked and not progress: blocked_cnt increments by 1, saturating at 2**CNT_W - 1.
  - Otherwise blocked_cnt returns to 0.
  - Counting and the detection check are evaluated in the same cycle.
  - When blocked_cnt == THRESH-1 and the counting condition holds:
    - Move to DEADLOCK and assert find_df_deadlock in the next cycle.
    - Latch dl_proc_mask = proc_active & blocked and dl_chan_mask = chan_rd_block | chan_wr_block, both sampled in the detection cycle.
  - If no process is active, return to IDLE and clear blocked_cnt.
- DEADLOCK:
  - Terminal.
  - find_df_deadlock, both masks and blocked_cnt hold their values.
  - All inputs are ignored except clear and reset.
- Latency: with the blocked condition held continuously from cycle 0, find_df_deadlock rises exactly THRESH cycles later.
- One cycle of channel progress, or one unblocked active process, restarts the count from 0. A single-cycle glitch never causes detection.
- clear has priority over everything except reset:
  - Next state is IDLE.
  - blocked_cnt, proc_active, both masks and the flag all go to 0.
- Reset asserted mid-count or in DEADLOCK behaves identically to power-on reset.

Optional Feature:
- Macro: DF_DEADLOCK_STALL_PROFILE_EN
- Defined:
  - Adds output stall_prof, NUM_PROC*CNT_W bits.
  - Holds one CNT_W-bit saturating counter per process.
  - A counter increments on each cycle its process is active and blocked, in any state except DEADLOCK.
  - All counters are cleared by reset or clear.
- Not defined: the port and the counters are absent. All other behaviour is identical.

Decomposition:
- Shared package df_dbg_pkg holds:
  - the state enum type dl_state_t (IDLE, MONITOR, DEADLOCK);
  - localparams for the state encodings;
  - a saturating-increment function.
- One natural sub-module, df_proc_tracker: per-process active register plus blocked qualification, instantiated NUM_PROC times with a generate loop.

Test Plan:
- Reset, then start process 0 and hold all stalls at 0 for 2000 cycles:
  - state reaches 1 one cycle after start;
  - blocked_cnt stays at 0;
  - find_df_deadlock stays at 0.
- THRESH=1000, all 3 processes active, proc_in_stall=3'b111, no rd/wr, chan_rd_block=3'b011:
  - find_df_deadlock rises exactly 1000 cycles after stall onset;
  - dl_proc_mask=3'b111, dl_chan_mask=3'b011.
- Same as the previous scenario but pulse chan_wr_en[1] at cycle 600:
  - blocked_cnt drops to 0;
  - deadlock is asserted 1000 cycles after the pulse, not before.
- All processes blocked except process 2 unblocked for a single cycle at cycle 999:
  - no detection at cycle 1000;
  - count restarts from 0.
- While in DEADLOCK, assert clear:
  - next cycle state=0, flag=0, both masks=0, blocked_cnt=0;
  - restarting the processes re-arms detection.
- Drop ap_rst_n at cycle 500 of a blocked run:
  - all outputs go to 0 immediately, without waiting for a clock edge;
  - after release, no detection occurs until a full THRESH-cycle blocked run.

Source files
------------

// File: rtl/df_dbg_pkg.sv
// df_dbg_pkg: shared FSM encodings and helpers for the dataflow deadlock detector.
package df_dbg_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MONITOR  = 2'd1;
    localparam logic [1:0] ST_DEADLOCK = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        MONITOR  = ST_MONITOR,
        DEADLOCK = ST_DEADLOCK
    } dl_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/df_proc_tracker.sv
// df_proc_tracker: per-process active flag (done beats start) and raw stall qualification.
module df_proc_tracker (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic start,
    input  logic done,
    input  logic in_stall,
    input  logic out_stall,
    input  logic hold,
    input  logic clr,
    output logic active,
    output logic blocked
);

    logic active_q, active_d;

    always_comb begin
        active_d = clr ? 1'b0 : hold ? active_q : done ? 1'b0 : start ? 1'b1 : active_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) active_q <= 1'b0;
        else           active_q <= active_d;
    end

    assign active  = active_q;
    assign blocked = in_stall | out_stall;

endmodule

// File: rtl/df_deadlock_detector.sv
// df_deadlock_detector: flags a sticky deadlock once every active process stays blocked with no channel traffic for THRESH cycles.
// Optional per-process stall profiling counters with DF_DEADLOCK_STALL_PROFILE_EN.
module df_deadlock_detector
    import df_dbg_pkg::*;
#(
    parameter int NUM_PROC = 3,
    parameter int NUM_CHAN = 3,
    parameter int THRESH   = 1000,
    parameter int CNT_W    = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [NUM_PROC-1:0]   proc_start,
    input  logic [NUM_PROC-1:0]   proc_done,
    input  logic [NUM_PROC-1:0]   proc_in_stall,
    input  logic [NUM_PROC-1:0]   proc_out_stall,
    input  logic [NUM_CHAN-1:0]   chan_rd_en,
    input  logic [NUM_CHAN-1:0]   chan_wr_en,
    input  logic [NUM_CHAN-1:0]   chan_rd_block,
    input  logic [NUM_CHAN-1:0]   chan_wr_block,
    input  logic                  clear,
`ifdef DF_DEADLOCK_STALL_PROFILE_EN
    output logic [NUM_PROC*CNT_W-1:0] stall_prof,
`endif
    output logic                  find_df_deadlock,
    output logic [NUM_PROC-1:0]   dl_proc_mask,
    output logic [NUM_CHAN-1:0]   dl_chan_mask,
    output logic [CNT_W-1:0]      blocked_cnt,
    output logic [1:0]            state
);

    localparam logic [31:0]      CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [CNT_W-1:0] DET_AT  = CNT_W'(THRESH - 1);

    dl_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 flag_q, flag_d;
    logic [NUM_PROC-1:0]  pmask_q, pmask_d;
    logic [NUM_CHAN-1:0]  cmask_q, cmask_d;
    logic [NUM_PROC-1:0]  active, blocked;
    logic                 all_blocked, progress, counting;

    for (genvar g = 0; g < NUM_PROC; g++) begin : g_trk
        df_proc_tracker u_trk (
            .ap_clk    (ap_clk),
            .ap_rst_n  (ap_rst_n),
            .start     (proc_start[g]),
            .done      (proc_done[g]),
            .in_stall  (proc_in_stall[g]),
            .out_stall (proc_out_stall[g]),
            .hold      (state_q == DEADLOCK),
            .clr       (clear),
            .active    (active[g]),
            .blocked   (blocked[g])
        );
    end

    assign all_blocked = (|active) && ((active & ~blocked) == '0);
    assign progress    = (|chan_rd_en) || (|chan_wr_en);
    assign counting    = all_blocked && !progress;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        pmask_d = pmask_q;
        cmask_d = cmask_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            flag_d  = 1'b0;
            pmask_d = '0;
            cmask_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = (|active) ? MONITOR : IDLE;
                end
                MONITOR: begin
                    if (!(|active)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (counting) begin
                        cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
                        // Detection uses the pre-increment count so the flag lands exactly THRESH cycles after onset.
                        if (cnt_q == DET_AT) begin
                            state_d = DEADLOCK;
                            flag_d  = 1'b1;
                            pmask_d = active & blocked;
                            cmask_d = chan_rd_block | chan_wr_block;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                DEADLOCK: state_d = DEADLOCK;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            pmask_q <= '0;
            cmask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            pmask_q <= pmask_d;
            cmask_q <= cmask_d;
        end
    end

    assign find_df_deadlock = flag_q;
    assign dl_proc_mask     = pmask_q;
    assign dl_chan_mask     = cmask_q;
    assign blocked_cnt      = cnt_q;
    assign state            = state_q;

`ifdef DF_DEADLOCK_STALL_PROFILE_EN
    logic [NUM_PROC-1:0][CNT_W-1:0] prof_q, prof_d;

    always_comb begin
        for (int i = 0; i < NUM_PROC; i++) begin
            prof_d[i] = clear ? '0
                      : (active[i] && blocked[i] && state_q != DEADLOCK) ? CNT_W'(sat_inc(32'(prof_q[i]), CNT_MAX))
                      : prof_q[i];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) prof_q <= '0;
        else           prof_q <= prof_d;
    end

    assign stall_prof = prof_q;
`endif

endmodule

// File: tb/tb_df_deadlock_detector.sv
// tb_df_deadlock_detector: directed scenarios plus random traffic, checked every cycle against a run-length model.
module tb_df_deadlock_detector;

    localparam int NP = 3;
    localparam int NC = 3;
    localparam int TH = 1000;
    localparam int CW = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [NP-1:0] proc_start = '0, proc_done = '0, proc_in_stall = '0, proc_out_stall = '0;
    logic [NC-1:0] chan_rd_en = '0, chan_wr_en = '0, chan_rd_block = '0, chan_wr_block = '0;
    logic          clear = 1'b0;
    logic          find_df_deadlock;
    logic [NP-1:0] dl_proc_mask;
    logic [NC-1:0] dl_chan_mask;
    logic [CW-1:0] blocked_cnt;
    logic [1:0]    state;

    int vectors = 0;
    int miscompares = 0;

    always #5 ap_clk = ~ap_clk;

    df_deadlock_detector #(.NUM_PROC(NP), .NUM_CHAN(NC), .THRESH(TH), .CNT_W(CW)) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .proc_start       (proc_start),
        .proc_done        (proc_done),
        .proc_in_stall    (proc_in_stall),
        .proc_out_stall   (proc_out_stall),
        .chan_rd_en       (chan_rd_en),
        .chan_wr_en       (chan_wr_en),
        .chan_rd_block    (chan_rd_block),
        .chan_wr_block    (chan_wr_block),
        .clear            (clear),
        .find_df_deadlock (find_df_deadlock),
        .dl_proc_mask     (dl_proc_mask),
        .dl_chan_mask     (dl_chan_mask),
        .blocked_cnt      (blocked_cnt),
        .state            (state)
    );

    // Reference: m_run is the length of the current uninterrupted stuck run while monitoring.
    logic [NP-1:0] m_act = '0;
    int            m_run = 0;
    int            m_state = 0;
    logic          m_flag = 1'b0;
    logic [NP-1:0] m_pm = '0;
    logic [NC-1:0] m_cm = '0;
    logic [NP-1:0] m_blk;
    logic          m_stuck;
    int            m_run_nx;

    assign m_blk    = proc_in_stall | proc_out_stall;
    assign m_stuck  = (m_act != '0) && ((m_act & ~m_blk) == '0) && (chan_rd_en == '0) && (chan_wr_en == '0);
    assign m_run_nx = m_stuck ? m_run + 1 : 0;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n || clear) begin
            m_act <= '0; m_run <= 0; m_state <= 0; m_flag <= 1'b0; m_pm <= '0; m_cm <= '0;
        end else if (m_state != 2) begin
            m_act <= (m_act | proc_start) & ~proc_done;
            if (m_state == 0) begin
                m_run <= 0;
                if (m_act != '0) m_state <= 1;
            end else if (m_act == '0) begin
                m_run <= 0;
                m_state <= 0;
            end else begin
                m_run <= m_run_nx;
                if (m_run_nx == TH) begin
                    m_state <= 2;
                    m_flag <= 1'b1;
                    m_pm <= m_act & m_blk;
                    m_cm <= chan_rd_block | chan_wr_block;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        #1;
        chk("state", int'(state), m_state);
        chk("flag", int'(find_df_deadlock), int'(m_flag));
        chk("blocked_cnt", int'(blocked_cnt), m_run);
        chk("dl_proc_mask", int'(dl_proc_mask), int'(m_pm));
        chk("dl_chan_mask", int'(dl_chan_mask), int'(m_cm));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic start_all();
        proc_start = '1;
        cyc();
        proc_start = '0;
    endtask

    task automatic wait_monitor();
        int n = 0;
        while (state != 2'd1 && n < 10) begin cyc(); n++; end
        chk("monitor_entry", int'(state), 1);
        chk("onset_cnt", int'(blocked_cnt), 0);
    endtask

    task automatic wait_flag(output int n);
        n = 0;
        while (!find_df_deadlock && n < 3 * TH) begin cyc(); n++; end
    endtask

    task automatic rand_phase(input int cycles, input int rare);
        for (int k = 0; k < cycles; k++) begin
            proc_start     = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
            proc_done      = ($urandom_range(0, 4 * rare) == 0) ? NP'($urandom) : '0;
            proc_in_stall  = ($urandom_range(0, rare) != 0) ? '1 : NP'($urandom);
            proc_out_stall = NP'($urandom);
            chan_rd_en     = ($urandom_range(0, rare) == 0) ? NC'($urandom) : '0;
            chan_wr_en     = ($urandom_range(0, rare) == 0) ? NC'($urandom) : '0;
            chan_rd_block  = NC'($urandom);
            chan_wr_block  = NC'($urandom);
            clear          = ($urandom_range(0, 3 * rare) == 0);
            cyc();
        end
        clear = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) cyc();
        chk("reset_state", int'(state), 0);
        chk("reset_flag", int'(find_df_deadlock), 0);
        ap_rst_n = 1'b1;
        cyc();

        // Active but never blocked: must never count.
        proc_start = 3'b001;
        cyc();
        proc_start = '0;
        wait_monitor();
        repeat (2000) cyc();
        chk("idle_run_cnt", int'(blocked_cnt), 0);
        chk("idle_run_flag", int'(find_df_deadlock), 0);
        do_clear();

        // Plain deadlock: exact latency and latched masks.
        proc_in_stall = 3'b111;
        chan_rd_block = 3'b011;
        start_all();
        wait_monitor();
        wait_flag(n);
        chk("latency_basic", n, TH);
        chk("pmask_basic", int'(dl_proc_mask), 3'b111);
        chk("cmask_basic", int'(dl_chan_mask), 3'b011);
        chk("state_deadlock", int'(state), 2);
        chan_rd_en = '1;
        proc_done = '1;
        repeat (5) cyc();
        chan_rd_en = '0;
        proc_done = '0;
        chk("deadlock_sticky", int'(find_df_deadlock), 1);
        chk("deadlock_cnt_hold", int'(blocked_cnt), TH);
        do_clear();

        // Progress pulse at cycle 600 restarts the count.
        start_all();
        wait_monitor();
        repeat (600) cyc();
        chan_wr_en = 3'b010;
        cyc();
        chan_wr_en = '0;
        chk("pulse_cnt_zero", int'(blocked_cnt), 0);
        wait_flag(n);
        chk("latency_after_pulse", n, TH);
        do_clear();

        // Process 2 unblocked for one cycle at count 999.
        start_all();
        wait_monitor();
        repeat (TH - 1) cyc();
        proc_in_stall = 3'b011;
        cyc();
        proc_in_stall = 3'b111;
        chk("glitch_no_flag", int'(find_df_deadlock), 0);
        chk("glitch_cnt_zero", int'(blocked_cnt), 0);
        wait_flag(n);
        chk("latency_after_glitch", n, TH);

        // Clear out of DEADLOCK, then re-arm.
        do_clear();
        chk("clr_state", int'(state), 0);
        chk("clr_flag", int'(find_df_deadlock), 0);
        chk("clr_pmask", int'(dl_proc_mask), 0);
        chk("clr_cmask", int'(dl_chan_mask), 0);
        chk("clr_cnt", int'(blocked_cnt), 0);
        start_all();
        wait_monitor();
        wait_flag(n);
        chk("latency_rearm", n, TH);
        do_clear();

        // Asynchronous reset mid-count.
        start_all();
        wait_monitor();
        repeat (500) cyc();
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("async_cnt", int'(blocked_cnt), 0);
        chk("async_state", int'(state), 0);
        chk("async_flag", int'(find_df_deadlock), 0);
        repeat (2) cyc();
        ap_rst_n = 1'b1;
        cyc();
        start_all();
        wait_monitor();
        wait_flag(n);
        chk("latency_after_reset", n, TH);
        do_clear();

        rand_phase(1500, 8);
        rand_phase(6000, 1500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
